pcpi_systolic_mm_n: RTL and testbench
=====================================

Name: pcpi_systolic_mm_n

Overview:
- Parametrised PCPI coprocessor for PicoRV32-style cores: an N x N skewed-wavefront matrix multiply with bias preload and per-element threshold.
- Successor to the fixed 3x3 matrix PCPI block. Adds generic N and data widths, register-operand element addressing, full load/compute/readback instruction set, accumulator saturation, and a packed threshold bitmask result.
- Sits on the core's PCPI bus. Custom-0 opcode instructions are decoded here.

Parameters:
- N, 3, matrix dimension; legal 2..5 so N*N <= 32.
- DW, 16, signed element width for A, B and bias.
- ACCW, 32, signed accumulator width; must be >= 2*DW and <= 32.
- OPCODE, 7'b0001011, major opcode claimed.
- THRESH_RST, -70, signed reset value of the threshold register.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- pcpi_valid  in  1  core presents an instruction; held until pcpi_ready
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  operand 1: select/index
- pcpi_rs2  in  32  operand 2: data
- pcpi_wr  out  1  write pcpi_rd to rd; qualified by pcpi_ready
- pcpi_rd  out  32  result
- pcpi_wait  out  1  stall request during compute
- pcpi_ready  out  1  one-cycle completion pulse
- busy  out  1  high in COMPUTE (debug/perf counter)

Behaviour:
- Reset: clk single clock; resetn asynchronous active-low. All outputs are 0. State is IDLE. A, B, bias and C are cleared. Threshold = THRESH_RST. Reset asserted mid-COMPUTE aborts the operation; no pcpi_ready is issued.
- Decode: accept only in IDLE, when pcpi_valid=1, insn[6:0]=OPCODE and funct3 is listed below. Otherwise do nothing: no ready, no wait.
- funct3=000 LOAD: rs1[17:16] selects the array (0=A, 1=B, 2=bias, 3=ignored). rs1[7:0]=idx, row=idx/N, col=idx%N. Element <= rs2[DW-1:0]. idx >= N*N writes nothing. Result rd=0, wr=1.
- funct3=001 SETTH: threshold <= rs2[ACCW-1:0]. rd=0, wr=1.
- funct3=010 READC: rd = C[rs1 idx] sign-extended to 32 bits; idx >= N*N returns 0. wr=1.
- funct3=101 CLEAR: C <= 0. rd=0, wr=1.
- funct3=111 START:
  - C[i][j] is first loaded from bias (sign-extended).
  - COMPUTE lasts exactly 3N-2 cycles, with step counter t=0..3N-3.
  - At step t, PE(i,j) with k=t-i-j in 0..N-1 does C[i][j] += A[i][k]*B[k][j]. The product is full 2*DW signed. The sum saturates to the ACCW signed min/max, and the saturated value persists.
  - Result rd bit (i*N+j) = (C[i][j] >= threshold), signed compare. Bits >= N*N are 0. wr=1.
- FSM: IDLE -> RESP (single-cycle ops) or IDLE -> COMPUTE (START). COMPUTE -> RESP when t=3N-3. RESP -> IDLE unconditionally.
- Timing: accept at edge T.
  - Single-cycle ops: pcpi_ready=1 during cycle T+1.
  - START: pcpi_wait=1 for cycles T+1..T+3N-2. pcpi_ready=1 at T+3N-1, with wait low in that cycle.
  - All outputs are registered. pcpi_rd and pcpi_wr are valid only while pcpi_ready=1, and are 0 otherwise.
- RESP ignores pcpi_valid, which is still high from the core. This prevents re-execution. A new instruction is accepted at the earliest in cycle T+2 (or T+3N after START).
- A, B, bias and threshold persist across STARTs. C persists until the next START, CLEAR or reset, so READC after START returns the final accumulators.
- pcpi_rs1/rs2 are sampled at the accept edge only.

Test Plan:
- N=3 reset check: outputs 0. READC idx 0..8 -> rd=0 each. START with all-zero A/B/bias -> ready at accept+8; rd=0x1FF (0 >= -70).
- N=3 identity: A=I, B=[[1,2,3],[4,5,6],[7,8,9]], bias=0, SETTH 5 -> START rd=0x1F0. READC idx4 -> 5, idx8 -> 9. pcpi_wait high exactly 7 cycles.
- Bias and negatives: A=-1*I, B=all 100, bias[1][1]=250, threshold -70 -> C=-100 except C[1][1]=150; rd=0x010.
- Saturation, DW=16/ACCW=32: A and B all -32768, bias all 0x7FFF. C=3*2^30+32767 clamps to 0x7FFFFFFF. READC idx0 -> 0x7FFFFFFF.
- Protocol: hold pcpi_valid through the RESP cycle -> exactly one pcpi_ready pulse. Wrong opcode, funct3=011, or LOAD idx 9 -> no ready for the first two; idx 9 gives ready but the array is unchanged.
- Reset mid-COMPUTE at step 3 -> outputs 0 immediately and no ready. After release, READC -> 0 and threshold is back to -70. Parameter sweep N=2 (latency 5) and N=5 (latency 14, rd bits 25..31 = 0).

Source files
------------

// File: rtl/pcpi_systolic_mm_n.sv
`default_nettype none
// ============================================================================
// Module   : pcpi_systolic_mm_n
// Purpose  : PCPI coprocessor for PicoRV32-style cores. Holds N x N operand
//            matrices A and B, a bias matrix and an accumulator matrix C, and
//            runs a skewed-wavefront (systolic-schedule) matrix multiply
//            C = bias + A*B with saturating accumulation. START returns a
//            packed bitmask of C[i][j] >= threshold.
// Ports    : clk         - clock
//            resetn      - asynchronous active-low reset
//            pcpi_valid  - core presents an instruction (held until ready)
//            pcpi_insn   - instruction word (custom opcode, funct3 selects op)
//            pcpi_rs1    - operand 1: array select [17:16], index [7:0]
//            pcpi_rs2    - operand 2: data
//            pcpi_wr     - write pcpi_rd to rd (qualified by pcpi_ready)
//            pcpi_rd     - result word
//            pcpi_wait   - stall request while computing
//            pcpi_ready  - one-cycle completion pulse
//            busy        - high while computing
// Revision : 1.0 - initial release
// ============================================================================
module pcpi_systolic_mm_n #(
    parameter int          N          = 3,
    parameter int          DW         = 16,
    parameter int          ACCW       = 32,
    parameter logic [6:0]  OPCODE     = 7'b0001011,
    parameter int          THRESH_RST = -70
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        busy
);

    localparam int NN = N * N;

    // FSM encoding
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_compute = 2'd1;
    localparam logic [1:0] c_st_resp    = 2'd2;

    // funct3 codes
    localparam logic [2:0] c_f3_load  = 3'b000;
    localparam logic [2:0] c_f3_setth = 3'b001;
    localparam logic [2:0] c_f3_readc = 3'b010;
    localparam logic [2:0] c_f3_clear = 3'b101;
    localparam logic [2:0] c_f3_start = 3'b111;

    // Last wavefront step: the anti-diagonal i+j+k reaches 3(N-1)
    localparam logic [7:0] c_last_step = 8'(3 * N - 3);
    localparam logic [7:0] c_nn        = 8'(NN);

    localparam logic signed [ACCW-1:0] c_acc_max = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] c_acc_min = {1'b1, {(ACCW-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [7:0]             r_step;
    logic                   r_wr;
    logic [31:0]            r_rd;
    logic                   r_wait;
    logic                   r_ready;
    logic                   r_busy;
    logic signed [ACCW-1:0] r_thresh;

    logic signed [DW-1:0]   r_a    [NN];
    logic signed [DW-1:0]   r_b    [NN];
    logic signed [DW-1:0]   r_bias [NN];
    logic signed [ACCW-1:0] r_c    [NN];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [2:0]  w_funct3;
    logic [1:0]  w_sel;
    logic [7:0]  w_idx;
    logic        w_f3_ok;
    logic        w_accept;
    logic [31:0] w_readc;

    assign w_funct3 = pcpi_insn[14:12];
    assign w_sel    = pcpi_rs1[17:16];
    assign w_idx    = pcpi_rs1[7:0];
    assign w_f3_ok  = (w_funct3 == c_f3_load)  || (w_funct3 == c_f3_setth) ||
                      (w_funct3 == c_f3_readc) || (w_funct3 == c_f3_clear) ||
                      (w_funct3 == c_f3_start);
    assign w_accept = (r_state == c_st_idle) && pcpi_valid &&
                      (pcpi_insn[6:0] == OPCODE) && w_f3_ok;

    // READC mux; an index outside the matrix matches nothing and reads 0
    always_comb begin
        w_readc = '0;
        for (int e = 0; e < NN; e++) begin
            if (w_idx == 8'(e)) begin
                w_readc = 32'(r_c[e]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Processing elements. PE(i,j) consumes A[i][k]*B[k][j] on the step
    // where t == i+j+k, which reproduces the skewed systolic wavefront
    // without physically shifting operands through the array.
    // ------------------------------------------------------------------
    logic signed [ACCW-1:0] w_c_next [NN];
    logic [NN-1:0]          w_mask;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic signed [2*DW-1:0] w_prod;
            logic signed [ACCW:0]   w_sum;

            always_comb begin
                w_prod = '0;
                for (int k = 0; k < N; k++) begin
                    if (int'(r_step) == gi + gj + k) begin
                        w_prod = (2*DW)'(r_a[gi*N+k]) * (2*DW)'(r_b[k*N+gj]);
                    end
                end
            end

            // One guard bit is enough: |product| <= 2^(2DW-2) <= 2^(ACCW-2)
            assign w_sum = (ACCW+1)'(r_c[gi*N+gj]) + (ACCW+1)'(w_prod);

            assign w_c_next[gi*N+gj] =
                (w_sum[ACCW] != w_sum[ACCW-1]) ?
                    (w_sum[ACCW] ? c_acc_min : c_acc_max) :
                    w_sum[ACCW-1:0];

            // Threshold uses the post-update value so the final step counts
            assign w_mask[gi*N+gj] = (w_c_next[gi*N+gj] >= r_thresh);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= c_st_idle;
            r_step   <= '0;
            r_wr     <= 1'b0;
            r_rd     <= '0;
            r_wait   <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_thresh <= ACCW'(THRESH_RST);
            for (int e = 0; e < NN; e++) begin
                r_a[e]    <= '0;
                r_b[e]    <= '0;
                r_bias[e] <= '0;
                r_c[e]    <= '0;
            end
        end else begin
            // Result strobes are pulses; rd/wr are zero outside the ready cycle
            r_ready <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= '0;

            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        case (w_funct3)
                            c_f3_load: begin
                                for (int e = 0; e < NN; e++) begin
                                    if (w_idx == 8'(e)) begin
                                        case (w_sel)
                                            2'd0:    r_a[e]    <= pcpi_rs2[DW-1:0];
                                            2'd1:    r_b[e]    <= pcpi_rs2[DW-1:0];
                                            2'd2:    r_bias[e] <= pcpi_rs2[DW-1:0];
                                            default: ;
                                        endcase
                                    end
                                end
                            end
                            c_f3_setth: r_thresh <= pcpi_rs2[ACCW-1:0];
                            c_f3_readc: r_rd     <= (w_idx < c_nn) ? w_readc : 32'd0;
                            c_f3_clear: begin
                                for (int e = 0; e < NN; e++) begin
                                    r_c[e] <= '0;
                                end
                            end
                            default: begin
                                // START: preload accumulators with bias
                                for (int e = 0; e < NN; e++) begin
                                    r_c[e] <= ACCW'(r_bias[e]);
                                end
                            end
                        endcase

                        if (w_funct3 == c_f3_start) begin
                            r_state <= c_st_compute;
                            r_step  <= '0;
                            r_wait  <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= c_st_resp;
                            r_ready <= 1'b1;
                            r_wr    <= 1'b1;
                        end
                    end
                end

                c_st_compute: begin
                    for (int e = 0; e < NN; e++) begin
                        r_c[e] <= w_c_next[e];
                    end
                    r_step <= r_step + 8'd1;
                    if (r_step == c_last_step) begin
                        r_state <= c_st_resp;
                        r_wait  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_wr    <= 1'b1;
                        r_rd    <= 32'(w_mask);
                    end
                end

                // The core still holds pcpi_valid here; ignoring it prevents
                // the same instruction from executing twice.
                c_st_resp: r_state <= c_st_idle;

                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign pcpi_wr    = r_wr;
    assign pcpi_rd    = r_rd;
    assign pcpi_wait  = r_wait;
    assign pcpi_ready = r_ready;
    assign busy       = r_busy;

    // Instruction and operand fields this block never looks at
    logic w_unused;
    assign w_unused = ^{pcpi_insn[31:15], pcpi_insn[11:7], pcpi_rs1[31:18],
                        pcpi_rs1[15:8], pcpi_rs2};

endmodule
`default_nettype wire

// File: tb/tb_pcpi_systolic_mm_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcpi_systolic_mm_n
// Purpose  : Directed self-checking bench for pcpi_systolic_mm_n. Three
//            instances (N=3, N=2, N=5) share the instruction/operand bus and
//            reset; each has its own pcpi_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcpi_systolic_mm_n;

    localparam logic [6:0] c_opc = 7'b0001011;

    logic        clk;
    logic        rst_n;
    logic [2:0]  r_valid;
    logic [31:0] r_insn;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [2:0]  w_wr;
    logic [2:0]  w_wait;
    logic [2:0]  w_ready;
    logic [2:0]  w_busy;
    logic [31:0] w_rd [3];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pcpi_systolic_mm_n #(.N(3)) u_dut3 (
        .clk(clk), .resetn(rst_n), .pcpi_valid(r_valid[0]), .pcpi_insn(r_insn),
        .pcpi_rs1(r_rs1), .pcpi_rs2(r_rs2), .pcpi_wr(w_wr[0]), .pcpi_rd(w_rd[0]),
        .pcpi_wait(w_wait[0]), .pcpi_ready(w_ready[0]), .busy(w_busy[0])
    );

    pcpi_systolic_mm_n #(.N(2)) u_dut2 (
        .clk(clk), .resetn(rst_n), .pcpi_valid(r_valid[1]), .pcpi_insn(r_insn),
        .pcpi_rs1(r_rs1), .pcpi_rs2(r_rs2), .pcpi_wr(w_wr[1]), .pcpi_rd(w_rd[1]),
        .pcpi_wait(w_wait[1]), .pcpi_ready(w_ready[1]), .busy(w_busy[1])
    );

    pcpi_systolic_mm_n #(.N(5)) u_dut5 (
        .clk(clk), .resetn(rst_n), .pcpi_valid(r_valid[2]), .pcpi_insn(r_insn),
        .pcpi_rs1(r_rs1), .pcpi_rs2(r_rs2), .pcpi_wr(w_wr[2]), .pcpi_rd(w_rd[2]),
        .pcpi_wait(w_wait[2]), .pcpi_ready(w_ready[2]), .busy(w_busy[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one instruction to instance d and wait (bounded) for pcpi_ready.
    // Valid stays high through the response cycle, as a real core would.
    task automatic exec(input int d, input logic [2:0] f3, input logic [31:0] a1,
                        input logic [31:0] a2, output logic [31:0] res,
                        output int lat, output int nwait, output int nbusy);
        @(negedge clk);
        r_insn = {17'd0, f3, 5'd1, c_opc};
        r_rs1  = a1;
        r_rs2  = a2;
        r_valid[d] = 1'b1;
        lat = 0; nwait = 0; nbusy = 0; res = '0;
        do begin
            @(negedge clk);
            lat++;
            // operands only matter at the accept edge
            r_rs1 = $urandom;
            r_rs2 = $urandom;
            if (w_wait[d]) nwait++;
            if (w_busy[d]) nbusy++;
        end while (!w_ready[d] && lat < 64);
        if (!w_ready[d]) begin
            check("ready_timeout", 32'(lat), 32'd0);
        end else begin
            res = w_rd[d];
            check("wr_at_ready", 32'(w_wr[d]), 32'd1);
            check("wait_at_ready", 32'(w_wait[d]), 32'd0);
        end
        @(negedge clk);
        check("single_ready_pulse", 32'(w_ready[d]), 32'd0);
        check("rd_idle_zero", w_rd[d], 32'd0);
        r_valid[d] = 1'b0;
    endtask

    task automatic ld(input int d, input logic [1:0] sel, input int idx, input logic [31:0] v);
        logic [31:0] r; int l, w, b;
        exec(d, 3'b000, {14'd0, sel, 8'd0, 8'(idx)}, v, r, l, w, b);
        check("load_rd", r, 32'd0);
    endtask

    task automatic setth(input int d, input logic [31:0] v);
        logic [31:0] r; int l, w, b;
        exec(d, 3'b001, 32'd0, v, r, l, w, b);
        check("setth_rd", r, 32'd0);
    endtask

    task automatic readc(input int d, input int idx, input logic [31:0] exp, input string tag);
        logic [31:0] r; int l, w, b;
        exec(d, 3'b010, {24'd0, 8'(idx)}, 32'd0, r, l, w, b);
        check(tag, r, exp);
        check("readc_latency", 32'(l), 32'd1);
    endtask

    task automatic start(input int d, input int n, input logic [31:0] exp, input string tag);
        logic [31:0] r; int l, w, b;
        exec(d, 3'b111, 32'd0, 32'd0, r, l, w, b);
        check(tag, r, exp);
        check("start_latency", 32'(l), 32'(3 * n - 1));
        check("wait_cycles", 32'(w), 32'(3 * n - 2));
        check("busy_cycles", 32'(b), 32'(3 * n - 2));
    endtask

    // Present an instruction that must be ignored; count any response.
    task automatic probe(input int d, input logic [31:0] ins, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        r_insn = ins; r_rs1 = 32'd0; r_rs2 = 32'h0000_1234;
        r_valid[d] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (w_ready[d] || w_wait[d]) n++;
        end
        r_valid[d] = 1'b0;
        check(tag, 32'(n), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        int l, w, b, n;

        rst_n = 1'b0; r_valid = '0; r_insn = '0; r_rs1 = '0; r_rs2 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- Reset state ----------------
        for (int d = 0; d < 3; d++) begin
            check("rst_flags", {28'd0, w_busy[d], w_wait[d], w_ready[d], w_wr[d]}, 32'd0);
            check("rst_rd", w_rd[d], 32'd0);
        end
        for (int i = 0; i < 9; i++) readc(0, i, 32'd0, "readc_after_reset");
        start(0, 3, 32'h0000_01FF, "start_zero");

        // ---------------- N=3 identity ----------------
        for (int i = 0; i < 9; i++) begin
            ld(0, 2'd0, i, (i % 4 == 0) ? 32'd1 : 32'd0);
            ld(0, 2'd1, i, 32'(i + 1));
        end
        setth(0, 32'd5);
        start(0, 3, 32'h0000_01F0, "start_identity");
        readc(0, 4, 32'd5, "readc_identity_4");
        readc(0, 8, 32'd9, "readc_identity_8");

        // Out-of-range LOAD: acknowledged but must not touch any array
        ld(0, 2'd0, 9, 32'd7);
        ld(0, 2'd1, 9, 32'd7);
        ld(0, 2'd2, 9, 32'd7);
        ld(0, 2'd3, 0, 32'd7);
        start(0, 3, 32'h0000_01F0, "start_after_idx9");
        for (int i = 0; i < 9; i++) readc(0, i, 32'(i + 1), "readc_after_idx9");
        readc(0, 9, 32'd0, "readc_idx9");

        // ---------------- Ignored instructions ----------------
        probe(0, {17'd0, 3'b000, 5'd1, 7'b0110011}, "wrong_opcode");
        probe(0, {17'd0, 3'b011, 5'd1, c_opc}, "bad_funct3");

        // ---------------- Bias and negatives ----------------
        for (int i = 0; i < 9; i++) begin
            if (i % 4 == 0) ld(0, 2'd0, i, 32'h0000_FFFF);
            ld(0, 2'd1, i, 32'd100);
        end
        ld(0, 2'd2, 4, 32'd250);
        setth(0, 32'hFFFF_FFBA);
        start(0, 3, 32'h0000_0010, "start_bias_neg");
        readc(0, 4, 32'd150, "readc_bias_4");
        readc(0, 0, 32'hFFFF_FF9C, "readc_neg_0");

        // ---------------- Saturation ----------------
        for (int i = 0; i < 9; i++) begin
            ld(0, 2'd0, i, 32'h0000_8000);
            ld(0, 2'd1, i, 32'h0000_8000);
            ld(0, 2'd2, i, 32'h0000_7FFF);
        end
        start(0, 3, 32'h0000_01FF, "start_sat");
        readc(0, 0, 32'h7FFF_FFFF, "readc_sat_0");
        readc(0, 8, 32'h7FFF_FFFF, "readc_sat_8");

        exec(0, 3'b101, 32'd0, 32'd0, r, l, w, b);
        check("clear_rd", r, 32'd0);
        readc(0, 8, 32'd0, "readc_after_clear");
        start(0, 3, 32'h0000_01FF, "start_sat_again");

        // ---------------- Reset mid-COMPUTE ----------------
        setth(0, 32'd5);
        @(negedge clk);
        r_insn = {17'd0, 3'b111, 5'd1, c_opc};
        r_valid[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("busy_before_reset", {30'd0, w_wait[0], w_busy[0]}, 32'd3);
        rst_n = 1'b0;
        r_valid[0] = 1'b0;
        #1;
        check("rst_async_flags", {28'd0, w_busy[0], w_wait[0], w_ready[0], w_wr[0]}, 32'd0);
        check("rst_async_rd", w_rd[0], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (w_ready[0] || w_wait[0]) n++;
        end
        check("no_ready_after_abort", 32'(n), 32'd0);
        readc(0, 4, 32'd0, "readc_after_abort");
        // C0 = -70 meets the reset threshold, C1 = -71 does not
        ld(0, 2'd2, 0, 32'h0000_FFBA);
        ld(0, 2'd2, 1, 32'h0000_FFB9);
        start(0, 3, 32'h0000_01FD, "start_thresh_reset");

        // ---------------- N=2 ----------------
        ld(1, 2'd0, 0, 32'd1); ld(1, 2'd0, 1, 32'd2);
        ld(1, 2'd0, 2, 32'd3); ld(1, 2'd0, 3, 32'd4);
        ld(1, 2'd1, 0, 32'd5); ld(1, 2'd1, 1, 32'd6);
        ld(1, 2'd1, 2, 32'd7); ld(1, 2'd1, 3, 32'd8);
        setth(1, 32'd40);
        start(1, 2, 32'h0000_000C, "start_n2");
        readc(1, 0, 32'd19, "readc_n2_0");
        readc(1, 1, 32'd22, "readc_n2_1");
        readc(1, 3, 32'd50, "readc_n2_3");
        readc(1, 4, 32'd0, "readc_n2_oob");

        // ---------------- N=5 ----------------
        for (int i = 0; i < 25; i++) begin
            if (i % 6 == 0) ld(2, 2'd0, i, 32'd1);
            ld(2, 2'd1, i, 32'(i - 12));
        end
        setth(2, 32'd0);
        start(2, 5, 32'h01FF_F000, "start_n5");
        readc(2, 0, 32'hFFFF_FFF4, "readc_n5_0");
        readc(2, 24, 32'd12, "readc_n5_24");
        readc(2, 25, 32'd0, "readc_n5_oob");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
